// File: rtl/nbit_alu.sv
// Registered N-bit ALU: eight operations selected by Mode,
// with carry/borrow/shift-out captured alongside the result.
module nbit_alu #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    input  logic [2:0]   Mode,
    output logic [N-1:0] Result,
    output logic         C_out
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [N:0] a_x;
    logic [N:0] b_x;
    logic [N:0] c_x;
    logic [N:0] alu_d;
    logic [N:0] alu_q;

    assign a_x = {1'b0, A};
    assign b_x = {1'b0, B};
    assign c_x = {{N{1'b0}}, C_in};

    // Bit N carries the carry, borrow (wrap of the N+1 bit difference),
    // or the bit shifted out; logic ops leave it clear.
    always_comb begin
        alu_d = '0;
        unique case (Mode)
            OP_ADD: alu_d = a_x + b_x + c_x;
            OP_SUB: alu_d = a_x - b_x - c_x;
            OP_AND: alu_d = {1'b0, A & B};
            OP_OR:  alu_d = {1'b0, A | B};
            OP_XOR: alu_d = {1'b0, A ^ B};
            OP_NOT: alu_d = {1'b0, ~A};
            OP_SHL: alu_d = {A, C_in};
            OP_SHR: alu_d = {A[0], C_in, A[N-1:1]};
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_d;
        end
    end

    assign Result = alu_q[N-1:0];
    assign C_out  = alu_q[N];

endmodule

// File: tb/tb_nbit_alu.sv
// Bench for nbit_alu (N=4): directed cases plus random mode cycling
// against an arithmetic reference model, with mid-stream reset.
module tb_nbit_alu;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       C_in;
    logic [2:0] Mode;
    logic [3:0] Result;
    logic       C_out;

    int checks;
    int errors;

    nbit_alu #(.N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .C_in   (C_in),
        .Mode   (Mode),
        .Result (Result),
        .C_out  (C_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model(int a, int b, int c, int m);
        int r;
        int co;
        r  = 0;
        co = 0;
        case (m)
            0: begin
                r  = a + b + c;
                co = r / 16;
                r  = r % 16;
            end
            1: begin
                co = (a < b + c) ? 1 : 0;
                r  = (a - b - c + 32) % 16;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin
                r  = (a * 2 + c) % 16;
                co = a / 8;
            end
            7: begin
                r  = c * 8 + a / 2;
                co = a % 2;
            end
            default: r = 0;
        endcase
        return {co[0], r[3:0]};
    endfunction

    // Drive one cycle's inputs and check the registered outputs one edge later
    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [2:0] m,
                         input logic r, input string tag);
        logic [4:0] exp;
        A    = a;
        B    = b;
        C_in = c;
        Mode = m;
        rst  = r;
        exp  = r ? 5'b0 : model(int'(a), int'(b), int'(c), int'(m));
        @(negedge clk);
        checks++;
        assert (Result === exp[3:0]) else begin
            errors++;
            $error("FAIL %s result got %b exp %b", tag, Result, exp[3:0]);
        end
        checks++;
        assert (C_out === exp[4]) else begin
            errors++;
            $error("FAIL %s cout got %b exp %b", tag, C_out, exp[4]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        A    = 4'b1111;
        B    = 4'b1111;
        C_in = 1'b0;
        Mode = 3'b000;

        apply(4'b1111, 4'b1111, 1'b0, 3'b000, 1'b1, "reset");
        apply(4'b1111, 4'b1111, 1'b0, 3'b000, 1'b0, "post_reset_add");

        apply(4'b1001, 4'b1010, 1'b0, 3'b000, 1'b0, "add_carry");
        apply(4'b0000, 4'b0011, 1'b1, 3'b000, 1'b0, "add_cin");

        apply(4'b1010, 4'b0011, 1'b0, 3'b001, 1'b0, "sub_a");
        apply(4'b1000, 4'b0111, 1'b0, 3'b001, 1'b0, "sub_b");
        apply(4'b0011, 4'b0101, 1'b0, 3'b001, 1'b0, "sub_borrow");
        apply(4'b1001, 4'b1001, 1'b1, 3'b001, 1'b0, "sub_eq_bin");

        apply(4'b1100, 4'b0011, 1'b1, 3'b010, 1'b0, "and");
        apply(4'b1011, 4'b0011, 1'b1, 3'b011, 1'b0, "or");
        apply(4'b1111, 4'b1110, 1'b1, 3'b100, 1'b0, "xor");
        apply(4'b1110, 4'b1011, 1'b1, 3'b101, 1'b0, "not");

        apply(4'b1010, 4'b0110, 1'b0, 3'b110, 1'b0, "shl_a");
        apply(4'b0101, 4'b1001, 1'b1, 3'b110, 1'b0, "shl_b");
        apply(4'b1001, 4'b0000, 1'b0, 3'b111, 1'b0, "shr_a");
        apply(4'b0001, 4'b1111, 1'b1, 3'b111, 1'b0, "shr_b");

        for (int rnd = 0; rnd < 8; rnd++) begin
            for (int m = 0; m < 8; m++) begin
                apply(4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)),
                      3'(m),
                      (rnd == 3 && m == 5),
                      "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbit_alu.md
# nbit_alu

Parameterised N-bit registered arithmetic/logic unit: selects one of eight operations on operands A and B via a 3-bit Mode code. Result and carry/borrow are registered on the clock edge. Used as a datapath primitive wherever a small synchronous ALU with carry-in/carry-out is needed; pure datapath, no handshake.

## Interface

Parameters:
- N, default 4: operand and result width in bits (N >= 2).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- A  input  N  operand A.
- B  input  N  operand B.
- C_in  input  1  carry-in / borrow-in / shift fill bit.
- Mode  input  3  operation select.
- Result  output  N  registered operation result.
- C_out  output  1  registered carry-out / borrow-out / shifted-out bit.

## Operation

Mode decode; all arithmetic is done at N+1 bits, then split into {C_out, Result}:
- 000 ADD: {C_out, Result} = A + B + C_in. C_out = carry out of bit N-1.
- 001 SUB: Result = (A - B - C_in) mod 2^N. C_out = 1 when borrow occurs, i.e. when A < B + C_in (unsigned).
- 010 AND: Result = A & B; C_out = 0.
- 011 OR: Result = A | B; C_out = 0.
- 100 XOR: Result = A ^ B; C_out = 0.
- 101 NOT: Result = ~A; B ignored; C_out = 0.
- 110 SHL: Result = {A[N-2:0], C_in}; C_out = A[N-1].
- 111 SHR: Result = {C_in, A[N-1:1]}; C_out = A[0].
- Operands are unsigned. No overflow flag.
- Inputs the selected operation does not use (B in NOT/SHL/SHR; C_in in logic ops) have no effect on the outputs.
- All eight codes are defined. There is no illegal-mode state.

## Timing

- Single pipeline stage. Inputs are sampled at rising edge k, and Result/C_out reflect that operation from edge k until edge k+1. Latency is 1 cycle, throughput is 1 op per cycle.
- Outputs are driven only from registers. No combinational path from inputs to outputs.
- Reset: if rst=1 at a rising edge, Result <= 0 and C_out <= 0, regardless of other inputs. rst has priority over any operation.
- Reset mid-stream: the operation sampled on a reset edge is discarded. The first edge with rst=0 loads a new result.
- Outputs are undefined (X) only before the first clock edge. Benches apply rst for at least one edge before checking.
- Back-to-back Mode changes on consecutive cycles are fully supported. Each cycle's result depends only on that cycle's inputs.

## Test plan

All values are for N=4; each check is made one cycle after the inputs are applied.
- Reset: rst=1 with A=1111, B=1111, Mode=000 -> Result=0000, C_out=0. Deassert rst, hold inputs -> Result=1110, C_out=1 on the next edge.
- ADD: A=1001, B=1010, C_in=0 -> 0011, C_out=1. A=0000, B=0011, C_in=1 -> 0100, C_out=0.
- SUB: A=1010, B=0011 -> 0111, C_out=0. A=1000, B=0111 -> 0001, C_out=0. A=0011, B=0101 -> 1110, C_out=1. A=1001, B=1001, C_in=1 -> 1111, C_out=1.
- Logic:
  - AND 1100 & 0011 -> 0000.
  - OR 1011 | 0011 -> 1011.
  - XOR 1111 ^ 1110 -> 0001.
  - NOT A=1110 (B=1011) -> 0001.
  - C_out=0 in every case, even with C_in=1.
- Shifts:
  - SHL A=1010, C_in=0 -> 0100, C_out=1.
  - SHL A=0101, C_in=1 -> 1011, C_out=0.
  - SHR A=1001, C_in=0 -> 0100, C_out=1.
  - SHR A=0001, C_in=1 -> 1000, C_out=1.
- Pipelining and reset priority: cycle through all eight modes on consecutive cycles with random A/B/C_in and compare against a reference model delayed by one cycle. Assert rst for one cycle mid-sequence -> outputs 0 for exactly that cycle, then correct results resume.
